lcd_seq: RTL and testbench

LCD_SEQ -- requirements
Module: lcd_seq

---
 rtl/lcd_seq_if.sv | 40 ++++
 rtl/lcd_seq.sv | 196 +++++++++++++++++++
 tb/tb_lcd_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_seq_if.sv
// Request handshake and HD44780 panel pins for the LCD write sequencer.
// master drives requests and observes the panel; slave is the sequencer.
interface lcd_seq_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_rs_i;
  logic [7:0] req_data_i;
  logic       busy_o;
  logic [7:0] lcd_data_o;
  logic       lcd_en_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_on_o;

  modport master (
    output req_valid_i,
    output req_rs_i,
    output req_data_i,
    input  req_ready_o,
    input  busy_o,
    input  lcd_data_o,
    input  lcd_en_o,
    input  lcd_rs_o,
    input  lcd_rw_o,
    input  lcd_on_o
  );

  modport slave (
    input  req_valid_i,
    input  req_rs_i,
    input  req_data_i,
    output req_ready_o,
    output busy_o,
    output lcd_data_o,
    output lcd_en_o,
    output lcd_rs_o,
    output lcd_rw_o,
    output lcd_on_o
  );
endinterface

// File: rtl/lcd_seq.sv
// HD44780 write sequencer: setup / EN pulse / hold / execute-wait per byte.
// Define LCD_SEQ_INIT_EN for a power-up wait plus built-in init sequence.
module lcd_seq #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 25,
  parameter int HOLD_CYC     = 2,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  lcd_seq_if.slave bus
);

  localparam int M0 =
    (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int M1 = (M0 > HOLD_CYC) ? M0 : HOLD_CYC;
  localparam int M2 = (M1 > WAIT_CYC) ? M1 : WAIT_CYC;
  localparam int M3 =
    (M2 > CLR_WAIT_CYC) ? M2 : CLR_WAIT_CYC;

`ifdef LCD_SEQ_INIT_EN
  localparam int PWR_CYC = 750000;
  localparam int MAXC = (M3 > PWR_CYC) ? M3 : PWR_CYC;
`else
  localparam int MAXC = M3;
`endif

  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] S1 = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] P1 = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] H1 = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] W1 = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] C1 = CW'(CLR_WAIT_CYC - 1);

`ifdef LCD_SEQ_INIT_EN
  localparam logic [CW-1:0] R1 = CW'(PWR_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, WAIT, PWR, INIT
  } state_t;

  localparam state_t RST_ST = PWR;
`else
  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, WAIT
  } state_t;

  localparam state_t RST_ST = IDLE;
`endif

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          rdy_q;
  logic          busy_q;
  logic          en_q;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          on_q;
  logic          clr_cmd;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait
  assign clr_cmd = !rs_q
                && (data_q[7:2] == 6'd0)
                && (data_q[1:0] != 2'd0);

`ifdef LCD_SEQ_INIT_EN
  logic [1:0] idx_q;
  logic       ini_q;
  logic [7:0] init_cmd;

  always_comb begin
    init_cmd = 8'h38;
    case (idx_q)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      on_q    <= 1'b0;
`ifdef LCD_SEQ_INIT_EN
      idx_q   <= 2'd0;
      ini_q   <= 1'b1;
`endif
    end else begin
      on_q <= 1'b1;
      case (state_q)
        IDLE: begin
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
          if (bus.req_valid_i && rdy_q) begin
            rs_q    <= bus.req_rs_i;
            data_q  <= bus.req_data_i;
            cnt_q   <= S1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            cnt_q   <= P1;
            state_q <= PULSE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            cnt_q   <= H1;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            cnt_q   <= clr_cmd ? C1 : W1;
            state_q <= WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
`ifdef LCD_SEQ_INIT_EN
            if (ini_q) begin
              state_q <= INIT;
            end else begin
              rdy_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
`else
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`ifdef LCD_SEQ_INIT_EN
        PWR: begin
          busy_q <= 1'b1;
          if (cnt_q == R1) begin
            cnt_q   <= '0;
            state_q <= INIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        INIT: begin
          busy_q  <= 1'b1;
          rs_q    <= 1'b0;
          data_q  <= init_cmd;
          cnt_q   <= S1;
          idx_q   <= idx_q + 2'd1;
          state_q <= SETUP;
          if (idx_q == 2'd3) begin
            ini_q <= 1'b0;
          end
        end
`endif
        default: begin
          en_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = rdy_q;
  assign bus.busy_o      = busy_q;
  assign bus.lcd_data_o  = data_q;
  assign bus.lcd_en_o    = en_q;
  assign bus.lcd_rs_o    = rs_q;
  assign bus.lcd_rw_o    = 1'b0;
  assign bus.lcd_on_o    = on_q;

endmodule

// File: tb/tb_lcd_seq.sv
// Directed bench for lcd_seq with shortened timing parameters.
// Normal write busy = 2+5+2+20 = 29 cycles, clear/home = 2+5+2+60 = 69.
module tb_lcd_seq;

  localparam int S  = 2;
  localparam int P  = 5;
  localparam int H  = 2;
  localparam int W  = 20;
  localparam int C  = 60;
  localparam int NRM = S + P + H + W;
  localparam int CLR = S + P + H + C;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vec;
  int   miss;

  lcd_seq_if bus ();

  lcd_seq #(
    .SETUP_CYC    (S),
    .PULSE_CYC    (P),
    .HOLD_CYC     (H),
    .WAIT_CYC     (W),
    .CLR_WAIT_CYC (C)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Issue one write and watch it until ready returns.
  // rise: edge offset of EN rising after the handshake edge.
  // bad: cycles where the panel data/rs differs from the request,
  // or ready and busy are both high.
  task automatic run_write(
    input  bit       rs,
    input  bit [7:0] d,
    input  bit       keep,
    input  bit       wiggle,
    output int       rise,
    output int       enlen,
    output int       busy_n,
    output int       bad,
    output int       hs
  );
    int k;
    rise   = -1;
    enlen  = 0;
    busy_n = -1;
    bad    = 0;
    hs     = -1;
    bus.req_rs_i    = rs;
    bus.req_data_i  = d;
    bus.req_valid_i = 1'b1;
    k = 0;
    while (!bus.req_ready_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready_o) begin
      bus.req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    hs = cyc;
    @(negedge clk);
    busy_n = 0;
    if (!keep) bus.req_valid_i = 1'b0;
    bus.req_data_i = ~d;
    bus.req_rs_i   = ~rs;
    for (k = 1; k < 500; k++) begin
      if (bus.lcd_en_o) begin
        if (rise < 0) rise = k - 1;
        enlen++;
      end
      if (bus.lcd_data_o !== d || bus.lcd_rs_o !== rs) bad++;
      if (bus.req_ready_o && bus.busy_o) bad++;
      if (bus.busy_o) busy_n++;
      if (bus.req_ready_o) break;
      if (wiggle) begin
        bus.req_valid_i = k[0];
        bus.req_data_i  = 8'($urandom);
        bus.req_rs_i    = k[1];
      end
      @(negedge clk);
    end
    if (!bus.req_ready_o) busy_n = -1;
    if (!keep) bus.req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_rs_i    = 1'b0;
    bus.req_data_i  = 8'h00;
    #23;
    vec++;
    if ({bus.lcd_en_o, bus.lcd_rs_o, bus.lcd_data_o} !== 10'h0) begin
      miss++;
      $display("FAIL reset_pins: got en/rs/data %b/%b/%h want 0/0/00",
               bus.lcd_en_o, bus.lcd_rs_o, bus.lcd_data_o);
    end
    vec++;
    if ({bus.req_ready_o, bus.busy_o, bus.lcd_on_o, bus.lcd_rw_o}
        !== 4'b0000) begin
      miss++;
      $display("FAIL reset_ctl: got rdy/busy/on/rw %b%b%b%b want 0000",
               bus.req_ready_o, bus.busy_o, bus.lcd_on_o, bus.lcd_rw_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if ({bus.req_ready_o, bus.lcd_on_o, bus.busy_o} !== 3'b110) begin
      miss++;
      $display("FAIL reset_release: got rdy/on/busy %b%b%b want 110",
               bus.req_ready_o, bus.lcd_on_o, bus.busy_o);
    end
  endtask

  task automatic test_data_write;
    int rise, enlen, bn, bad, hs;
    run_write(1'b1, 8'h41, 1'b0, 1'b0, rise, enlen, bn, bad, hs);
    vec++;
    if (rise !== S) begin
      miss++;
      $display("FAIL data_en_rise: got %0d want %0d", rise, S);
    end
    vec++;
    if (enlen !== P) begin
      miss++;
      $display("FAIL data_en_len: got %0d want %0d", enlen, P);
    end
    vec++;
    if (bn !== NRM) begin
      miss++;
      $display("FAIL data_busy: got %0d want %0d", bn, NRM);
    end
    vec++;
    if (bad !== 0) begin
      miss++;
      $display("FAIL data_pins: got %0d bad cycles want 0", bad);
    end
    vec++;
    if (bus.lcd_rw_o !== 1'b0) begin
      miss++;
      $display("FAIL data_rw: got %b want 0", bus.lcd_rw_o);
    end
  endtask

  task automatic test_commands;
    bit [8:0] cmd [6];
    int       exp [6];
    int rise, enlen, bn, bad, hs;
    cmd = '{9'h001, 9'h080, 9'h003, 9'h004, 9'h002, 9'h101};
    exp = '{CLR, NRM, CLR, NRM, CLR, NRM};
    for (int i = 0; i < 6; i++) begin
      run_write(cmd[i][8], cmd[i][7:0], 1'b0, 1'b0,
                rise, enlen, bn, bad, hs);
      vec++;
      if (bn !== exp[i] || bad !== 0) begin
        miss++;
        $display("FAIL cmd_%h: got busy %0d bad %0d want %0d/0",
                 cmd[i], bn, bad, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit [7:0] d [3];
    int hst [3];
    int rise, enlen, bn, bad;
    d = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      run_write(1'b1, d[i], i < 2, 1'b0, rise, enlen, bn, bad, hst[i]);
      vec++;
      if (enlen !== P || bad !== 0 || bn !== NRM) begin
        miss++;
        $display("FAIL b2b_%0d: got en %0d bad %0d busy %0d want %0d/0/%0d",
                 i, enlen, bad, bn, P, NRM);
      end
    end
    for (int i = 1; i < 3; i++) begin
      vec++;
      if (hst[i] - hst[i-1] !== NRM + 1) begin
        miss++;
        $display("FAIL b2b_gap_%0d: got %0d want %0d",
                 i, hst[i] - hst[i-1], NRM + 1);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int rise, enlen, bn, bad, hs;
    run_write(1'b1, 8'hA5, 1'b0, 1'b1, rise, enlen, bn, bad, hs);
    vec++;
    if (bn !== NRM || bad !== 0) begin
      miss++;
      $display("FAIL ignore_busy: got busy %0d bad %0d want %0d/0",
               bn, bad, NRM);
    end
    bus.req_data_i = 8'h5A;
    bus.req_rs_i   = 1'b0;
    repeat (4) @(negedge clk);
    vec++;
    if (bus.lcd_data_o !== 8'hA5 || bus.lcd_rs_o !== 1'b1) begin
      miss++;
      $display("FAIL ignore_idle: got %b/%h want 1/a5",
               bus.lcd_rs_o, bus.lcd_data_o);
    end
  endtask

  task automatic test_reset_pulse;
    int k;
    int rise, enlen, bn, bad, hs;
    bus.req_rs_i    = 1'b1;
    bus.req_data_i  = 8'hC3;
    bus.req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    k = 0;
    while (!bus.lcd_en_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (bus.lcd_en_o !== 1'b1 || bus.lcd_data_o !== 8'hC3) begin
      miss++;
      $display("FAIL rstp_pulse: got en %b data %h want 1/c3",
               bus.lcd_en_o, bus.lcd_data_o);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (bus.lcd_en_o !== 1'b0 || bus.lcd_data_o !== 8'h00
        || bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
      miss++;
      $display("FAIL rstp_async: got en %b data %h busy %b rdy %b",
               bus.lcd_en_o, bus.lcd_data_o, bus.busy_o,
               bus.req_ready_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (bus.req_ready_o !== 1'b1 || bus.lcd_en_o !== 1'b0) begin
      miss++;
      $display("FAIL rstp_release: got rdy %b en %b want 1/0",
               bus.req_ready_o, bus.lcd_en_o);
    end
    run_write(1'b0, 8'h80, 1'b0, 1'b0, rise, enlen, bn, bad, hs);
    vec++;
    if (rise !== S || enlen !== P || bn !== NRM || bad !== 0) begin
      miss++;
      $display("FAIL rstp_restart: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/0",
               rise, enlen, bn, bad, S, P, NRM);
    end
  endtask

  initial begin
    cyc  = 0;
    vec  = 0;
    miss = 0;
    test_reset();
    test_data_write();
    test_commands();
    test_back_to_back();
    test_busy_ignore();
    test_reset_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
